fpdiv_iter: RTL and testbench



---
 rtl/fpdiv_pkg.sv | 19 +
 rtl/fpdiv_if.sv | 24 ++
 rtl/fpdiv_lzc24.sv | 15 +
 rtl/fpdiv_iter.sv | 182 ++++++++++++++++++
 tb/tb_fpdiv_iter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpdiv_pkg.sv
// Shared types and binary32 constants for the iterative divider.
package fpdiv_pkg;

  typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  localparam int          F32_EXP_BIAS = 127;
  localparam int          F32_MANT_W   = 23;
  localparam logic [31:0] F32_QNAN     = 32'h7FC00000;
  localparam int          DIV_ITERS    = 26;

endpackage

// File: rtl/fpdiv_if.sv
// Operand/result handshake bundle between a requester and fpdiv_iter.
interface fpdiv_if;
  import fpdiv_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  flags_t      flags;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, flags
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, flags
  );

endinterface

// File: rtl/fpdiv_lzc24.sv
// Combinational leading-zero count of a 24-bit significand (24 when all zero).
module lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (value[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fpdiv_iter.sv
// Sequential binary32 divider: radix-2 restoring quotient, one bit per cycle, RNE rounding.
module fpdiv_iter
  import fpdiv_pkg::*;
(
  input logic   clk,
  input logic   rst_n,
  fpdiv_if.slave bus
);

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [31:0] a_reg, b_reg;
  logic [25:0] rem, quo;
  logic [31:0] result;
  flags_t      result_flags;

  logic [7:0]  ea_f, eb_f;
  logic [23:0] ma_raw, mb_raw, ma, mb;
  logic [4:0]  lza, lzb;
  logic signed [9:0] ea, eb, e_prep;
  logic        sign;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic        special;
  logic [31:0] sp_result;
  flags_t      sp_flags;
  logic [26:0] step;

  function automatic logic [26:0] div_step(input logic [25:0] r, input logic [23:0] d);
    logic        ge;
    logic [25:0] diff;
    ge   = r >= {2'b00, d};
    diff = ge ? r - {2'b00, d} : r;
    return {ge, diff[24:0], 1'b0};
  endfunction

  function automatic logic [36:0] round_pack(input logic sgn, input logic signed [9:0] exp_in,
                                             input logic [25:0] qv, input logic rem_nz);
    logic [23:0]       sig;
    logic              guard, sticky, tiny, inc, ovf;
    logic signed [9:0] ex, shift_s;
    logic [4:0]        shamt;
    logic [50:0]       wide;
    logic [24:0]       sig_r;
    logic [9:0]        ex_m1;
    logic [32:0]       packed_v;
    logic [31:0]       res;
    flags_t            fl;
    if (qv[25]) begin
      sig = qv[25:2]; guard = qv[1]; sticky = qv[0] | rem_nz; ex = exp_in;
    end else begin
      sig = qv[24:1]; guard = qv[0]; sticky = rem_nz; ex = exp_in - 10'sd1;
    end
    // Tiny results denormalize before rounding; 26 places already clears everything.
    tiny    = (ex <= 10'sd0);
    shift_s = 10'sd1 - ex;
    shamt   = (shift_s > 10'sd26) ? 5'd26 : shift_s[4:0];
    wide    = {sig, guard, 26'b0} >> (tiny ? shamt : 5'd0);
    if (tiny) begin
      sig    = wide[50:27];
      guard  = wide[26];
      sticky = sticky | (|wide[25:0]);
      ex     = 10'sd1;
    end
    inc   = guard & (sticky | sig[0]);
    sig_r = {1'b0, sig} + {24'b0, inc};
    // Adding the significand onto (e-1)<<23 lets a rounding carry bump the exponent.
    ex_m1    = ex - 10'sd1;
    packed_v = {ex_m1, 23'b0} + {8'b0, sig_r};
    ovf      = packed_v[32:23] >= 10'd255;
    fl       = '0;
    fl.nx    = guard | sticky;
    fl.uf    = tiny & (guard | sticky);
    res      = {sgn, packed_v[30:0]};
    if (ovf) begin
      res   = {sgn, 8'hFF, 23'b0};
      fl.of = 1'b1;
      fl.nx = 1'b1;
    end
    return {fl, res};
  endfunction

  assign ea_f   = a_reg[30:23];
  assign eb_f   = b_reg[30:23];
  assign ma_raw = {|ea_f, a_reg[F32_MANT_W-1:0]};
  assign mb_raw = {|eb_f, b_reg[F32_MANT_W-1:0]};

  lzc24 u_lzc_a (.value(ma_raw), .count(lza));
  lzc24 u_lzc_b (.value(mb_raw), .count(lzb));

  assign ma     = ma_raw << lza;
  assign mb     = mb_raw << lzb;
  assign ea     = $signed({2'b00, (ea_f == 8'd0) ? 8'd1 : ea_f}) - $signed({5'b0, lza});
  assign eb     = $signed({2'b00, (eb_f == 8'd0) ? 8'd1 : eb_f}) - $signed({5'b0, lzb});
  assign e_prep = ea - eb + 10'(F32_EXP_BIAS);
  assign sign   = a_reg[31] ^ b_reg[31];

  assign a_nan  = (&ea_f) & (|a_reg[22:0]);
  assign b_nan  = (&eb_f) & (|b_reg[22:0]);
  assign a_snan = a_nan & ~a_reg[22];
  assign b_snan = b_nan & ~b_reg[22];
  assign a_inf  = (&ea_f) & ~(|a_reg[22:0]);
  assign b_inf  = (&eb_f) & ~(|b_reg[22:0]);
  assign a_zero = ~(|a_reg[30:0]);
  assign b_zero = ~(|b_reg[30:0]);

  always_comb begin
    special   = 1'b1;
    sp_result = F32_QNAN;
    sp_flags  = '0;
    if (a_nan || b_nan) begin
      sp_flags.nv = a_snan | b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_flags.nv = 1'b1;
    end else if (a_inf) begin
      sp_result = {sign, 8'hFF, 23'b0};
    end else if (b_zero) begin
      sp_result   = {sign, 8'hFF, 23'b0};
      sp_flags.dz = 1'b1;
    end else if (a_zero || b_inf) begin
      sp_result = {sign, 31'b0};
    end else begin
      special = 1'b0;
    end
  end

  // Iteration 0 is taken on the PREP edge straight from the normalized dividend.
  assign step = div_step((state == PREP) ? {2'b00, ma} : rem, mb);

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = PREP;
      end
      PREP:  state_next = special ? DONE : DIV;
      DIV:   if (cnt == 5'(DIV_ITERS - 1)) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      result       <= '0;
      result_flags <= '0;
    end else begin
      state <= state_next;
      if (state == PREP)     cnt <= 5'd1;
      else if (state == DIV) cnt <= cnt + 5'd1;
      if (state == PREP && special) begin
        result       <= sp_result;
        result_flags <= sp_flags;
      end else if (state == ROUND) begin
        {result_flags, result} <= round_pack(sign, e_prep, quo, |rem);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_reg <= bus.dividend;
      b_reg <= bus.divisor;
    end
    if (state == PREP || state == DIV) begin
      quo <= {quo[24:0], step[26]};
      rem <= step[25:0];
    end
  end

  assign bus.quotient = result;
  assign bus.flags    = result_flags;

endmodule

// File: tb/tb_fpdiv_iter.sv
// Bench for fpdiv_iter: directed vectors plus random operands against an exact-division model.
module tb_fpdiv_iter;
  import fpdiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fpdiv_if bus();

  fpdiv_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_sp(input logic [31:0] x);
    return (x[30:0] == 31'd0) || (x[30:23] == 8'hFF);
  endfunction

  // Reference: exact long division of raw significands, rounded to the binary32 grid.
  function automatic logic [36:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic         s, a_nan, b_nan, a_inf, b_inf, a_z, b_z;
    logic         half, low, tiny, of, nx, uf;
    logic [127:0] ma, mb, num, n, rr, kept, mask;
    logic [31:0]  r;
    int           xa, xb, p, lexp, lsb, sh, fld;
    s     = a[31] ^ b[31];
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_z   = (a[30:0] == 0);
    b_z   = (b[30:0] == 0);
    if (a_nan || b_nan) begin
      if ((a_nan && !a[22]) || (b_nan && !b[22])) return {5'h10, 32'h7FC00000};
      return {5'h00, 32'h7FC00000};
    end
    if ((a_z && b_z) || (a_inf && b_inf)) return {5'h10, 32'h7FC00000};
    if (a_inf) return {5'h00, s, 8'hFF, 23'b0};
    if (b_z)   return {5'h08, s, 8'hFF, 23'b0};
    if (a_z || b_inf) return {5'h00, s, 31'b0};
    xa  = ((a[30:23] == 0) ? 1 : int'(a[30:23])) - 150;
    xb  = ((b[30:23] == 0) ? 1 : int'(b[30:23])) - 150;
    ma  = {104'b0, (a[30:23] != 0), a[22:0]};
    mb  = {104'b0, (b[30:23] != 0), b[22:0]};
    num = ma << 60;
    n   = num / mb;
    rr  = num % mb;
    p   = 0;
    for (int i = 0; i < 128; i++) if (n[i]) p = i;
    lexp = p + xa - xb - 60;
    tiny = (lexp < -126);
    lsb  = tiny ? -149 : lexp - 23;
    sh   = lsb - (xa - xb - 60);
    if (sh > 127) sh = 127;
    kept = n >> sh;
    half = n[sh-1];
    mask = (128'd1 << (sh - 1)) - 128'd1;
    low  = ((n & mask) != 0) || (rr != 0);
    if (half && (low || kept[0])) kept = kept + 128'd1;
    nx = half | low;
    of = 1'b0;
    if (tiny) begin
      r = {s, kept[30:0]};
    end else begin
      if (kept[24]) begin
        kept = kept >> 1;
        lexp++;
      end
      fld = lexp + 127;
      if (fld >= 255) begin
        r  = {s, 8'hFF, 23'b0};
        of = 1'b1;
        nx = 1'b1;
      end else begin
        r = {s, 8'(fld), kept[22:0]};
      end
    end
    uf = tiny && nx;
    return {2'b00, of, uf, nx, r};
  endfunction

  function automatic logic [31:0] rand_f32();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = $urandom_range(0, 23);
    case (k)
      0:       v[30:0] = '0;
      1:       v[30:0] = {8'hFF, 23'b0};
      2:       v[30:22] = 9'h1FF;
      3: begin
        v[30:22] = 9'h1FE;
        if (v[21:0] == 0) v[0] = 1'b1;
      end
      4, 5:    v[30:23] = 8'h00;
      6:       v[30:23] = 8'($urandom_range(1, 4));
      7:       v[30:23] = 8'($urandom_range(250, 254));
      8, 9, 10: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(110, 144));
    endcase
    return v;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_q, input logic [4:0] exp_f,
                        input int exp_lat, input int hold);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    bus.in_valid = 1'($urandom_range(0, 1));
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      bus.in_valid = 1'($urandom_range(0, 1));
    end
    bus.in_valid = 1'b0;
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (exp_lat > 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_quotient"}, 64'(bus.quotient), 64'(exp_q));
    check({tag, "_flags"}, 64'(bus.flags), 64'(exp_f));
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_quotient"}, 64'(bus.quotient), 64'(exp_q));
      check({tag, "_hold_flags"}, 64'(bus.flags), 64'(exp_f));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_after_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_after_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [36:0] m;
    int          n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    #3;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_quotient", 64'(bus.quotient), 64'd0);
    check("rst_flags", 64'(bus.flags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",    32'h3F800000, 32'h40000000, 32'h3F000000, 5'h00, 28, 5);
    run_op("round",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28, 0);
    run_op("uf_tie",   32'h00000001, 32'h40000000, 32'h00000000, 5'h03, 28, 0);
    run_op("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'h05, 28, 1);
    run_op("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 2, 0);
    run_op("zero_zero",32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 2, 0);
    run_op("snan",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'h10, 2, 2);

    // Abort in the middle of the iteration.
    start_op(32'h40490FDB, 32'h3F3504F3);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_div_ready", 64'(bus.in_ready), 64'd1);
    check("abort_div_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort while a result is waiting for the consumer.
    start_op(32'h3F800000, 32'h40000000);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_done_reached", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_done_valid", 64'(bus.out_valid), 64'd0);
    check("abort_done_quotient", 64'(bus.quotient), 64'd0);
    check("abort_done_flags", 64'(bus.flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28, 0);

    for (int i = 0; i < 250; i++) begin
      a = rand_f32();
      b = rand_f32();
      m = ref_div(a, b);
      run_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, m[31:0], m[36:32],
             (is_sp(a) || is_sp(b)) ? 2 : 28, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
